rr_encoder_param: RTL and testbench

RR_ENCODER_PARAM -- requirements
Module: rr_encoder_param

---
 rtl/rr_encoder_param_pkg.sv | 8 +
 rtl/prio_encoder_param.sv | 25 ++
 rtl/rr_encoder_param.sv | 99 +++++++++
 tb/tb_rr_encoder_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rr_encoder_param_pkg.sv
// Shared default geometry for the round-robin encoder family.
// Holds only the default index width and requester count.
package rr_encoder_param_pkg;

    localparam int RR_BITS_DEF = 2;
    localparam int RR_SIZE_DEF = 4;

endpackage

// File: rtl/prio_encoder_param.sv
// Stateless fixed-priority encoder: the lowest set bit wins.
// Produces a binary index plus an any-valid flag.
module prio_encoder_param
    import rr_encoder_param_pkg::*;
#(
    parameter int BITS = RR_BITS_DEF,
    parameter int SIZE = RR_SIZE_DEF
) (
    input  logic [SIZE-1:0] i_vec,
    output logic [BITS-1:0] o_idx,
    output logic            o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        // Scan downward so the lowest set index is the last one written.
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = BITS'(i);
            end
        end
    end

endmodule

// File: rtl/rr_encoder_param.sv
// Round-robin multi-hot to binary encoder with a registered grant and a ready handshake.
// The candidates are rotated by ptr, fed to a fixed-priority encoder, and the result is rotated back.
module rr_encoder_param
    import rr_encoder_param_pkg::*;
#(
    parameter int BITS = RR_BITS_DEF,
    parameter int SIZE = RR_SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] req,
    input  logic            out_ready,
    output logic [BITS-1:0] out,
    output logic            out_valid,
    output logic [SIZE-1:0] req_ack,
    output logic            err
);

    localparam int NSLOT = 2 ** BITS;

    logic [BITS-1:0]  r_out;
    logic             r_valid;
    logic [BITS-1:0]  r_ptr;
    logic             r_err;

    logic [NSLOT-1:0] w_req_ext;
    logic [NSLOT-1:0] w_out_oh;
    logic [NSLOT-1:0] w_cand_ext;
    logic [SIZE-1:0]  w_rot;
    logic [BITS-1:0]  w_pidx;
    logic             w_pany;
    logic [BITS:0]    w_gsum;
    logic [BITS-1:0]  w_grant;
    logic [BITS-1:0]  w_ptr_inc;
    logic             w_load;
    logic             w_accept;

    // Pad to 2**BITS slots so that any BITS-wide index is a legal select.
    assign w_req_ext  = NSLOT'(req);
    assign w_out_oh   = {{(NSLOT-1){1'b0}}, 1'b1} << r_out;
    assign w_load     = !r_valid || out_ready;
    assign w_accept   = r_valid && out_ready;
    assign w_cand_ext = r_valid ? (w_req_ext & ~w_out_oh) : w_req_ext;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_rot
            logic [BITS:0]   w_sum;
            logic [BITS-1:0] w_src;
            assign w_sum     = (BITS+1)'(gi) + {1'b0, r_ptr};
            assign w_src     = (w_sum >= (BITS+1)'(SIZE)) ? BITS'(w_sum - (BITS+1)'(SIZE))
                                                          : BITS'(w_sum);
            assign w_rot[gi] = w_cand_ext[w_src];
        end
    endgenerate

    prio_encoder_param #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_prio (
        .i_vec (w_rot),
        .o_idx (w_pidx),
        .o_any (w_pany)
    );

    // Undo the rotation: grant = (pidx + ptr) mod SIZE.
    assign w_gsum    = {1'b0, w_pidx} + {1'b0, r_ptr};
    assign w_grant   = (w_gsum >= (BITS+1)'(SIZE)) ? BITS'(w_gsum - (BITS+1)'(SIZE))
                                                   : BITS'(w_gsum);
    assign w_ptr_inc = (r_out == BITS'(SIZE - 1)) ? '0 : r_out + BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= w_pany;
                if (w_pany) begin
                    r_out <= w_grant;
                end
            end
            if (w_accept) begin
                r_ptr <= w_ptr_inc;
            end
            // A granted requester that drops before its ack is a protocol violation.
            if (r_valid && !w_req_ext[r_out]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign err       = r_err;
    assign req_ack   = w_accept ? w_out_oh[SIZE-1:0] : '0;

endmodule

// File: tb/tb_rr_encoder_param.sv
// Bench for rr_encoder_param: directed scenarios plus a protocol-respecting random phase,
// checked against a search-based round-robin reference model.
module tb_rr_encoder_param;

    localparam int BITS = 2;
    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SIZE-1:0] req = '0;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] out;
    logic            out_valid;
    logic [SIZE-1:0] req_ack;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    int m_out, m_valid, m_ptr, m_err;
    logic [SIZE-1:0] m_last_ack;

    rr_encoder_param #(.BITS(BITS), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .req_ack   (req_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_valid = 0; m_ptr = 0; m_err = 0;
        m_last_ack = '0;
    endtask

    function automatic logic [SIZE-1:0] model_ack();
        logic [SIZE-1:0] a;
        a = '0;
        if (m_valid != 0 && out_ready) a[m_out] = 1'b1;
        return a;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_out"},   32'(out),       32'(m_out));
        chk({tag, "_err"},   32'(err),       32'(m_err));
        chk({tag, "_ack"},   32'(req_ack),   32'(model_ack()));
    endtask

    // One clock of the reference: search from ptr for the next requester, wrapping around.
    task automatic model_step();
        int nptr;
        logic [SIZE-1:0] c;
        int found;
        nptr = m_ptr;
        if (m_valid != 0 && !req[m_out]) m_err = 1;
        if (m_valid != 0 && out_ready) nptr = (m_out + 1) % SIZE;
        if (m_valid == 0 || out_ready) begin
            c = req;
            if (m_valid != 0) c[m_out] = 1'b0;
            found = 0;
            for (int k = 0; k < SIZE; k++) begin
                int j;
                j = (m_ptr + k) % SIZE;
                if (c[j] && found == 0) begin
                    found = 1;
                    m_out = j;
                end
            end
            m_valid = found;
        end
        m_ptr = nptr;
    endtask

    task automatic cycle(input logic [SIZE-1:0] r, input logic rdy, input string tag);
        req = r;
        out_ready = rdy;
        #1;
        check_outputs(tag);
        m_last_ack = model_ack();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [SIZE-1:0] r);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        #1;
        req = r;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        rst_n = 1'b1;

        // Single requester from idle: one-cycle latency, ptr moves past it.
        cycle(4'b0100, 1'b1, "r030a");
        chk("r030_valid", 32'(out_valid), 32'd1);
        chk("r030_out",   32'(out),       32'd2);
        chk("r030_ack",   32'(req_ack),   32'(4'b0100));
        cycle(4'b0100, 1'b1, "r030b");
        cycle(4'b0000, 1'b1, "r030c");

        // Pointer at 3: search wraps to 0, then continues to 2.
        cycle(4'b0101, 1'b1, "r033a");
        chk("r033_out0", 32'(out), 32'd0);
        cycle(4'b0101, 1'b1, "r033b");
        chk("r033_out2", 32'(out), 32'd2);
        cycle(4'b0100, 1'b1, "r033c");
        cycle(4'b0000, 1'b1, "r033d");

        // All requesting with constant ready: 0,1,2,3,0 back to back.
        do_reset('0);
        cycle(4'b1111, 1'b1, "r031i");
        for (int i = 0; i < 5; i++) begin
            chk("r031_seq",   32'(out),       32'(i % SIZE));
            chk("r031_valid", 32'(out_valid), 32'd1);
            if (i < 4) cycle(4'b1111, 1'b1, "r031");
        end
        cycle(4'b1111, 1'b1, "r031x");
        chk("r032_out1", 32'(out), 32'd1);

        // Stall: grant must hold while the request pattern changes.
        for (int i = 0; i < 5; i++) cycle(4'b1011, 1'b0, "r032hold");
        chk("r032_held", 32'(out), 32'd1);
        cycle(4'b1011, 1'b1, "r032acc");
        chk("r032_next", 32'(out), 32'd3);

        // Reset while a grant is held, then re-grant from ptr 0.
        cycle(4'b1001, 1'b0, "r035hold");
        do_reset(4'b1000);
        cycle(4'b1000, 1'b1, "r035a");
        chk("r035_out", 32'(out), 32'd3);
        cycle(4'b1000, 1'b1, "r035b");
        cycle(4'b0000, 1'b1, "r035c");

        // Granted requester drops before ack: sticky err until reset.
        cycle(4'b0010, 1'b0, "r034a");
        chk("r034_out", 32'(out), 32'd1);
        cycle(4'b0000, 1'b0, "r034b");
        chk("r034_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, "r034sticky");
        chk("r034_still", 32'(err), 32'd1);
        do_reset('0);
        chk("r034_clr", 32'(err), 32'd0);

        // Random phase: requests hold until acked, ready toggles, occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic [SIZE-1:0] nr;
            logic rdy;
            for (int i = 0; i < SIZE; i++) begin
                if (req[i] && !m_last_ack[i]) nr[i] = 1'b1;
                else nr[i] = ($urandom_range(0, 99) < 40);
            end
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                do_reset(nr);
                m_last_ack = '0;
            end
            cycle(nr, rdy, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
